ntt_tf_scheduler: RTL and testbench

- Sequencer driving the twiddle-factor address generator and butterfly array of the radix-4 4x2-BFU NTT core.
- On start, walks all five stages (p) and, within each stage, all twiddle indices (k), producing one (k, p, conf) tuple per accepted beat.
- Inserts a pipeline-drain gap between stages and reports busy/done to the top-level controller.

---
 rtl/ntt_tf_scheduler.sv | 156 +++++++++++++++
 tb/tb_ntt_tf_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_tf_scheduler.sv
// Twiddle (k, p, conf) sequencer for the radix-4 4x2-BFU NTT core.
// Optional cycle counter: define NTT_TF_SCHED_PERF_CNT_EN.
module ntt_tf_scheduler #(
  parameter int STAGE_BEATS = 128,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       conf,
  input  logic             hold,
  output logic             busy,
  output logic             valid,
  output logic [6:0]       k,
  output logic [2:0]       p,
  output logic [2:0]       conf_o,
  output logic             stage_last,
  output logic             done
`ifdef NTT_TF_SCHED_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam int BW = $clog2(STAGE_BEATS);
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(STAGE_BEATS - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state;
  logic [BW-1:0] beat;
  logic [GW-1:0] gap_cnt;
  logic          fwd;

  logic [BW-1:0] beat_nx;
  logic [2:0]    p_nx;
  logic          last_stage;
  logic          start_fwd;

  always_comb begin
    beat_nx    = beat + 1'b1;
    p_nx       = fwd ? p - 3'd1 : p + 3'd1;
    last_stage = fwd ? (p == 3'd0) : (p == 3'd4);
    start_fwd  = (conf == 3'b001) || (conf == 3'b100);
  end

  // k = beat * K_p / STAGE_BEATS, with K_p = 1,4,16,64,128 for p=4..0
  function automatic logic [6:0] k_of(
    input logic [BW-1:0] b,
    input logic [2:0]    pp
  );
    int sh;
    case (pp)
      3'd4:    sh = BW;
      3'd3:    sh = BW - 2;
      3'd2:    sh = BW - 4;
      3'd1:    sh = BW - 6;
      default: sh = BW - 7;
    endcase
    return 7'(b >> sh);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      beat       <= '0;
      gap_cnt    <= '0;
      fwd        <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      k          <= '0;
      p          <= '0;
      conf_o     <= '0;
      stage_last <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            valid      <= 1'b1;
            fwd        <= start_fwd;
            conf_o     <= conf;
            p          <= start_fwd ? 3'd4 : 3'd0;
            k          <= '0;
            beat       <= '0;
            stage_last <= 1'b0;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (beat == BEAT_LAST) begin
              beat       <= '0;
              k          <= '0;
              stage_last <= 1'b0;
              if (last_stage) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
                valid <= 1'b0;
                p     <= '0;
              end else if (STAGE_GAP == 0) begin
                p <= p_nx;
              end else begin
                state   <= S_GAP;
                valid   <= 1'b0;
                p       <= p_nx;
                gap_cnt <= '0;
              end
            end else begin
              beat       <= beat_nx;
              k          <= k_of(beat_nx, p);
              stage_last <= (beat_nx == BEAT_LAST);
            end
          end
        end
        S_GAP: begin
          if (!hold) begin
            if (gap_cnt == GAP_LAST) begin
              state <= S_RUN;
              valid <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NTT_TF_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy && cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_tf_scheduler.sv
// Scoreboard bench for ntt_tf_scheduler against a tuple-list model.
// Checks cycle_cnt too when NTT_TF_SCHED_PERF_CNT_EN is defined.
module tb_ntt_tf_scheduler;
  localparam int SB = 128;
  localparam int G  = 4;
  localparam int RUN_LEN = 5 * SB + 4 * G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, hold;
  logic [2:0] conf;
  logic       busy, valid, stage_last, done;
  logic [6:0] k;
  logic [2:0] p, conf_o;

  logic       start0;
  logic       busy0, valid0, stage_last0, done0;
  logic [6:0] k0;
  logic [2:0] p0, conf_o0;
`ifdef NTT_TF_SCHED_PERF_CNT_EN
  logic [15:0] cycle_cnt, cycle_cnt0;
`endif

  ntt_tf_scheduler #(.STAGE_BEATS(SB), .STAGE_GAP(G)) dut (
    .clk(clk), .rst(rst), .start(start), .conf(conf),
    .hold(hold), .busy(busy), .valid(valid), .k(k), .p(p),
    .conf_o(conf_o), .stage_last(stage_last), .done(done)
`ifdef NTT_TF_SCHED_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  ntt_tf_scheduler #(.STAGE_BEATS(SB), .STAGE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .conf(3'b001),
    .hold(1'b0), .busy(busy0), .valid(valid0), .k(k0), .p(p0),
    .conf_o(conf_o0), .stage_last(stage_last0), .done(done0)
`ifdef NTT_TF_SCHED_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt0)
`endif
  );

  typedef enum {IT_BEAT, IT_GAP, IT_DONE} kind_t;
  typedef struct {
    kind_t    kind;
    int       k;
    int       p;
    bit       last;
    logic [2:0] conf;
  } item_t;

  item_t sbq[$];
  int tests = 0;
  int fails = 0;
  int hold_cnt = 0;
  int len_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected tuple stream of one full transform, straight from the rules
  task automatic push_transform(input logic [2:0] c);
    bit f;
    f = (c == 3'b001) || (c == 3'b100);
    for (int s = 0; s < 5; s++) begin
      int pp, kp, rep;
      pp  = f ? 4 - s : s;
      kp  = (pp == 0) ? 128 : (1 << (2 * (4 - pp)));
      rep = SB / kp;
      for (int b = 0; b < SB; b++)
        sbq.push_back('{IT_BEAT, b / rep, pp, b == SB - 1, c});
      if (s < 4)
        for (int g = 0; g < G; g++)
          sbq.push_back('{IT_GAP, 0, f ? pp - 1 : pp + 1, 1'b0, c});
    end
    sbq.push_back('{IT_DONE, 0, 0, 1'b0, c});
  endtask

  // Monitor: compare against the queue head, pop on accepted beats
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_cnt = 0;
        len_cnt  = 0;
      end else if (busy || done || valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_activity", {busy, done, valid}, 0);
        end else begin
          item_t it;
          it = sbq[0];
          if (done) begin
            chk("done_kind", it.kind == IT_DONE, 1);
            chk("done_busy", busy, 0);
            chk("done_valid", valid, 0);
            chk("run_length", len_cnt, RUN_LEN + hold_cnt);
`ifdef NTT_TF_SCHED_PERF_CNT_EN
            chk("cycle_cnt", cycle_cnt, RUN_LEN + hold_cnt);
`endif
            if (it.kind == IT_DONE) void'(sbq.pop_front());
            else sbq.delete();
            hold_cnt = 0;
            len_cnt  = 0;
          end else begin
            len_cnt++;
            if (hold) hold_cnt++;
            chk("busy", busy, 1);
            if (valid) begin
              chk("beat_kind", it.kind == IT_BEAT, 1);
              chk("k", k, it.k);
              chk("p", p, it.p);
              chk("stage_last", stage_last, it.last);
              chk("conf_o", conf_o, it.conf);
            end else begin
              chk("gap_kind", it.kind == IT_GAP, 1);
              chk("gap_k", k, 0);
              chk("gap_p", p, it.p);
              chk("gap_stage_last", stage_last, 0);
            end
            if (!hold) void'(sbq.pop_front());
          end
        end
      end
    end
  end

  task automatic do_start(input logic [2:0] c);
    @(posedge clk); #1;
    start = 1'b1;
    conf  = c;
    push_transform(c);
    @(posedge clk); #1;
    start = 1'b0;
    conf  = 3'($urandom);
    chk("first_valid", valid, 1);
    chk("first_busy", busy, 1);
  endtask

  task automatic wait_idle(input bit rnd_hold);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 4000) begin
      @(posedge clk); #1;
      hold = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
      n++;
    end
    hold = 1'b0;
    chk("transform_completes", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic wait_tuple(input int wp, input int wk, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(posedge clk); #1;
      ok = valid && (p == 3'(wp)) && (k == 7'(wk));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_k"}, k, 0);
    chk({tag, "_p"}, p, 0);
    chk({tag, "_conf_o"}, conf_o, 0);
    chk({tag, "_stage_last"}, stage_last, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    bit ok;
    int beats, lasts, drops, first_p;
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    conf = 3'b000; start0 = 1'b0;
    #2;
    chk_all_zero("reset");
`ifdef NTT_TF_SCHED_PERF_CNT_EN
    chk("reset_cycle_cnt", cycle_cnt, 0);
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    do_start(3'b001);
    wait_idle(1'b0);

    // inverse run, with a start pulse landing on the done cycle
    do_start(3'b010);
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(posedge clk); #1;
      ok = done;
    end
    chk("inv_done_seen", ok, 1);
    start = 1'b1;
    conf  = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    repeat (2) @(posedge clk);
    #1 chk("still_idle", busy, 0);
    sbq.delete();

    // hold at p=2,k=7 second beat, then a start while busy
    do_start(3'b001);
    wait_tuple(2, 7, ok);
    chk("found_p2_k7", ok, 1);
    @(posedge clk); #1;
    hold = 1'b1;
    repeat (5) @(posedge clk);
    #1 hold = 1'b0;
    start = 1'b1;
    conf  = 3'b100;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(1'b0);

    repeat (3) begin
      do_start(3'($urandom_range(0, 7)));
      wait_idle(1'b1);
    end

    // asynchronous reset mid-stage at p=1
    do_start(3'b001);
    wait_tuple(1, 10, ok);
    chk("found_p1", ok, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("midrun_rst");
    sbq.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_in_rst", done, 0);
    end
    rst = 1'b1;
    do_start(3'b010);
    wait_idle(1'b0);

    // back-to-back stages with STAGE_GAP=0
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    first_p = p0;
    beats = 0; lasts = 0; drops = 0;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (done0) ok = 1'b1;
      else begin
        if (valid0) beats++;
        if (stage_last0) lasts++;
        if (busy0 && !valid0) drops++;
      end
    end
    chk("gap0_done_seen", ok, 1);
    chk("gap0_first_p", first_p, 4);
    chk("gap0_beats", beats, 5 * SB);
    chk("gap0_stage_last", lasts, 5);
    chk("gap0_valid_drops", drops, 0);
`ifdef NTT_TF_SCHED_PERF_CNT_EN
    chk("gap0_cycle_cnt", cycle_cnt0, 5 * SB);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
